// File: rtl/pipe_prefetch_buffer.sv
// Instruction prefetch queue sitting between instruction memory and ID.
// Fetches sequential words ahead of decode, buffers up to DEPTH {pc, inst}
// pairs, presents the head entry to ID and flushes on a branch/jump redirect.
module pipe_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        wip,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid
);
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      r_fetch_pc;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem_pc   [DEPTH];
    logic [31:0]      r_mem_inst [DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;

    // Handshake and queue-occupancy decode; redirect masks the request so a
    // flush cycle never pushes a stale-stream word.
    always_comb begin
        w_full    = (r_count == FULL_CNT);
        valid     = (r_count != '0);
        imem_req  = ~w_full & ~redirect;
        imem_addr = r_fetch_pc;
        w_push    = imem_req & imem_ack;
        w_pop     = wip & valid;
        inst      = valid ? r_mem_inst[r_rd_ptr] : 32'h0;
        pc        = valid ? r_mem_pc[r_rd_ptr]   : r_fetch_pc;
    end

    // Control state: fetch address, pointers and occupancy; redirect wins
    // over any push or pop in the same cycle.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_ONE;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is not reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_inst[r_wr_ptr] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_pipe_prefetch_buffer.sv
// Self-checking bench for pipe_prefetch_buffer: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_pipe_prefetch_buffer;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        clrn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        wip;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;

    int total = 0;
    int bad   = 0;
    string phase = "reset";

    // Reference model: FIFO of {pc, inst} plus the next fetch address.
    logic [63:0] mq[$];
    logic [31:0] m_fpc;

    pipe_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .clrn(clrn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .wip(wip), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst(inst), .pc(pc), .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [31:0] einst;
        logic [31:0] epc;
        ev    = (mq.size() != 0);
        einst = ev ? mq[0][31:0]  : 32'h0;
        epc   = ev ? mq[0][63:32] : m_fpc;
        chk("valid", {31'b0, valid}, {31'b0, ev});
        chk("inst", inst, einst);
        chk("pc", pc, epc);
        chk("imem_addr", imem_addr, m_fpc);
        chk("imem_req", {31'b0, imem_req},
            {31'b0, (mq.size() != DEPTH) && !redirect});
    endtask

    // One clock cycle: drive inputs just after the edge, check before the
    // next edge, then advance the model across that edge.
    task automatic cyc(input logic ack, input logic w, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] rdata);
        logic m_req;
        imem_ack    = ack;
        wip         = w;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rdata  = rdata;
        #3;
        check_outputs();
        m_req = (mq.size() != DEPTH) && !rd;
        @(posedge clk);
        if (rd) begin
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (w && mq.size() != 0) void'(mq.pop_front());
            if (m_req && ack) begin
                mq.push_back({m_fpc, rdata});
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
    endtask

    // Fetch cycle where memory returns the word address as the instruction.
    task automatic fcyc(input logic ack, input logic w);
        cyc(ack, w, 1'b0, 32'h0, m_fpc);
    endtask

    task automatic redir(input logic [31:0] rpc);
        cyc(1'b1, 1'b0, 1'b1, rpc, 32'hDEAD_BEEF);
    endtask

    initial begin
        clrn = 1'b0; imem_ack = 1'b0; wip = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        mq.delete();
        m_fpc = RST_PC;
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        clrn = 1'b1;

        phase = "stream";
        for (int i = 0; i < 10; i++) fcyc(1'b1, 1'b1);

        phase = "fill";
        redir(32'h0);
        for (int i = 0; i < 6; i++) fcyc(1'b1, 1'b0);
        phase = "full_pop";
        fcyc(1'b1, 1'b1);
        fcyc(1'b1, 1'b0);
        fcyc(1'b1, 1'b0);
        phase = "drain";
        for (int i = 0; i < 5; i++) fcyc(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) fcyc(1'b1, 1'b1);

        phase = "redirect3";
        redir(32'h0);
        for (int i = 0; i < 3; i++) fcyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0103, 32'h1234_5678);
        for (int i = 0; i < 4; i++) fcyc(1'b1, 1'b1);

        phase = "ack_low";
        redir(32'h0000_0200);
        for (int i = 0; i < 5; i++) fcyc(1'b0, i[0]);
        fcyc(1'b1, 1'b0);

        phase = "redir_hold";
        redir(32'h0000_0300);
        redir(32'h0000_0404);
        redir(32'h0000_0507);
        fcyc(1'b1, 1'b1);
        fcyc(1'b1, 1'b1);

        phase = "async_rst";
        redir(32'h0000_0038);
        fcyc(1'b1, 1'b0);
        fcyc(1'b1, 1'b0);
        clrn = 1'b0;
        mq.delete();
        m_fpc = RST_PC;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        clrn = 1'b1;
        for (int i = 0; i < 3; i++) fcyc(1'b1, 1'b1);

        phase = "wrap";
        redir(32'hFFFF_FFFC);
        fcyc(1'b1, 1'b0);
        fcyc(1'b1, 1'b0);
        fcyc(1'b0, 1'b1);
        fcyc(1'b0, 1'b1);
        fcyc(1'b0, 1'b1);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
